// File: rtl/noc_input_port_buffer.sv
// -----------------------------------------------------------------------------
// noc_input_port_buffer
//
// Router input-port stage that sits on the injection link of a processing
// element. Incoming flits on a valid-only link are stored in a DEPTH-entry
// FIFO. Each flit that leaves the FIFO returns one registered credit pulse on
// co to the PE. The head flit is presented to the switch allocator together
// with an XY-routed output-port request.
//
// Optional feature (compile-time macro NOC_IBUF_BYPASS_EN):
//   When defined, an empty FIFO with in_valid=1 and out_ready=1 in the same
//   cycle forwards in_flit combinationally to out_flit. The flit is not
//   written to storage, and co still pulses on the following cycle. When the
//   macro is undefined, all head outputs come from FIFO state only, and the
//   minimum latency is one cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_flit    in   flit from upstream PE (DATA_W bits)
//   in_valid   in   qualifier for in_flit (valid-only, no backpressure)
//   co         out  credit return, one-cycle pulse per popped flit
//   out_flit   out  head-of-FIFO flit (zero when empty)
//   out_valid  out  head flit available
//   out_ready  in   switch grant
//   out_port   out  route request: 0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH
//   occupancy  out  number of stored entries (0..DEPTH)
//   err_ovf    out  sticky overflow flag, cleared only by rst
//
// Flit format: [DATA_W-1 -: 2] dest Y, [DATA_W-3 -: 2] dest X, rest payload.
//
// Handshake semantics: upstream has no ready. A flit is offered whenever
// in_valid=1, and upstream only sends while it holds credits. Downstream is a
// strict valid/ready pair: a flit transfers on every rising edge where
// out_valid & out_ready. out_ready while out_valid=0 has no effect.
// -----------------------------------------------------------------------------
module noc_input_port_buffer #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 7,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                in_flit,
  input  logic                             in_valid,
  output logic                             co,
  output logic [DATA_W-1:0]                out_flit,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2:0]                       out_port,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy,
  output logic                             err_ovf
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [1:0]       MX       = 2'(MY_X);
  localparam logic [1:0]       MY       = 2'(MY_Y);

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_EAST  = 3'd1;
  localparam logic [2:0] PORT_WEST  = 3'd2;
  localparam logic [2:0] PORT_NORTH = 3'd3;
  localparam logic [2:0] PORT_SOUTH = 3'd4;

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic empty;
  logic full;
  logic byp_fire;   // flit passes straight through an empty FIFO
  logic pop;        // a flit leaves this stage (from storage or bypass)
  logic fifo_rd;    // the pop comes out of storage
  logic fifo_wr;    // incoming flit is written to storage
  logic ovf;        // incoming flit is dropped

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

`ifdef NOC_IBUF_BYPASS_EN
  assign byp_fire = empty & in_valid & out_ready;
`else
  assign byp_fire = 1'b0;
`endif

  assign out_valid = ~empty | byp_fire;
  assign pop       = out_valid & out_ready;
  assign fifo_rd   = pop & ~empty;
  // A pop in the same cycle frees the slot the new flit needs, even when full.
  assign fifo_wr   = in_valid & (~full | pop) & ~byp_fire;
  assign ovf       = in_valid & full & ~pop;

  // DEPTH need not be a power of two, so pointers wrap by explicit compare.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + 1'b1;
    end
  endfunction

  // Storage is not reset: out_flit is masked to zero while count is zero,
  // so uninitialised entries are never visible.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      co      <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (fifo_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (fifo_wr && !fifo_rd) begin
        count <= count + 1'b1;
      end else if (!fifo_wr && fifo_rd) begin
        count <= count - 1'b1;
      end
      // One credit per departing flit, including bypassed ones.
      co <= pop;
      if (ovf) begin
        err_ovf <= 1'b1;
      end
    end
  end

  assign occupancy = count;

  // ---------------------------------------------------------------------------
  // Head presentation and XY routing
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] head_flit;

  always_comb begin
    head_flit = '0;
    if (!empty) begin
      head_flit = mem[rd_ptr];
    end else if (byp_fire) begin
      head_flit = in_flit;
    end
  end

  assign out_flit = head_flit;

  // X is resolved first, then Y; a flit at its own router ejects locally.
  always_comb begin
    logic [1:0] dx;
    logic [1:0] dy;
    dy       = head_flit[DATA_W-1 -: 2];
    dx       = head_flit[DATA_W-3 -: 2];
    out_port = PORT_LOCAL;
    if (out_valid) begin
      if (dx > MX) begin
        out_port = PORT_EAST;
      end else if (dx < MX) begin
        out_port = PORT_WEST;
      end else if (dy > MY) begin
        out_port = PORT_NORTH;
      end else if (dy < MY) begin
        out_port = PORT_SOUTH;
      end else begin
        out_port = PORT_LOCAL;
      end
    end
  end

endmodule
